// File: rtl/pc_fetch_unit_if.sv
// Request/response bundle between decode and the program-counter stage.
// Decode drives redirect/control requests; the fetch unit returns PCinst and status.
interface pc_fetch_unit_if;
    logic       stall;
    logic       branch_taken;
    logic [4:0] branch_offset;
    logic       jump;
    logic [7:0] jump_target;
    logic       call;
    logic       ret;
    logic       halt;
    logic       resume;
    logic [7:0] PCinst;
    logic       pc_valid;
    logic       halted;
    logic       ras_err;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
        output call, ret, halt, resume,
        input  PCinst, pc_valid, halted, ras_err
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
        input  call, ret, halt, resume,
        output PCinst, pc_valid, halted, ras_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: sequential, relative branch, absolute jump and halt, one address per clock.
// Define PC_RETURN_STACK_EN to add a RAS_DEPTH-entry return-address stack for call/ret.
module pc_fetch_unit #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         RAS_DEPTH    = 4
) (
    input logic            clk,
    input logic            rst,
    pc_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic       r_valid;
    logic       r_halted;

    logic [7:0] w_pc_inc;
    logic [7:0] w_br_target;
    logic [7:0] w_top;
    logic       w_push;
    logic       w_pop;
    logic       w_ras_fault;

    assign w_pc_inc    = r_pc + 8'd1;
    assign w_br_target = r_pc + {{3{bus.branch_offset[4]}}, bus.branch_offset};

`ifdef PC_RETURN_STACK_EN
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  r_sp;
    logic [7:0]       r_stack [RAS_DEPTH];
    logic             r_ras_err;
    logic             w_free;
    logic             w_ret_req;
    logic             w_call_req;
    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_top_idx;

    // call/ret only act when no higher-priority request claims the cycle
    assign w_free      = (r_state == RUN) && !bus.halt && !bus.stall && !bus.jump;
    assign w_ret_req   = w_free && bus.ret;
    assign w_call_req  = w_free && !bus.ret && bus.call;
    assign w_full      = (r_sp == SP_W'(RAS_DEPTH));
    assign w_empty     = (r_sp == '0);
    assign w_push      = w_call_req && !w_full;
    assign w_pop       = w_ret_req && !w_empty;
    assign w_ras_fault = (w_call_req && w_full) || (w_ret_req && w_empty);
    assign w_top_idx   = IDX_W'(r_sp - 1'b1);
    assign w_top       = r_stack[w_top_idx];

    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_sp[IDX_W-1:0]] <= w_pc_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp      <= '0;
            r_ras_err <= 1'b0;
        end else begin
            r_ras_err <= w_ras_fault;
            if (w_push)     r_sp <= r_sp + 1'b1;
            else if (w_pop) r_sp <= r_sp - 1'b1;
        end
    end

    assign bus.ras_err = r_ras_err;
`else
    logic w_unused;

    assign w_unused    = ^{bus.call, bus.ret, 8'(RAS_DEPTH)};
    assign w_push      = 1'b0;
    assign w_pop       = 1'b0;
    assign w_ras_fault = 1'b0;
    assign w_top       = 8'h00;
    assign bus.ras_err = 1'b0;
`endif

    // Control FSM; PC and status flags are all registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= BOOT;
            r_pc     <= RESET_VECTOR;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                RUN: begin
                    if (bus.halt) begin
                        r_state  <= HALT;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (bus.stall)        r_pc <= r_pc;
                    else if (bus.jump)             r_pc <= bus.jump_target;
                    else if (w_pop)                r_pc <= w_top;
                    else if (w_push)               r_pc <= bus.jump_target;
                    else if (w_ras_fault)          r_pc <= w_pc_inc;
                    else if (bus.branch_taken)     r_pc <= w_br_target;
                    else                           r_pc <= w_pc_inc;
                end
                HALT: begin
                    if (bus.resume && !bus.halt) begin
                        r_state  <= RUN;
                        r_valid  <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= BOOT;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCinst   = r_pc;
    assign bus.pc_valid = r_valid;
    assign bus.halted   = r_halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a behavioural model queues the expected outputs per cycle.
// Exercises the return stack as well when PC_RETURN_STACK_EN is defined.
module tb_pc_fetch_unit;

`ifdef PC_RETURN_STACK_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int MODEL_DEPTH = 4;

    typedef struct packed {
        logic [7:0] pc;
        logic       valid;
        logic       halted;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    exp_t       sbQueue[$];
    int         mState;
    logic [7:0] mPc;
    logic       mValid;
    logic       mHalted;
    logic       mErr;
    logic [7:0] mStack[$];

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mState  = 0;
        mPc     = 8'h00;
        mValid  = 1'b0;
        mHalted = 1'b0;
        mErr    = 1'b0;
        mStack.delete();
        sbQueue.delete();
    endtask

    // One model step per clock, mirroring the priority order of the fetch stage
    task automatic modelStep(input logic st, br, input logic [4:0] off, input logic jp,
                             input logic [7:0] tgt, input logic cl, rt, hl, rs);
        mErr = 1'b0;
        case (mState)
            0: begin mState = 1; mValid = 1'b1; end
            1: begin
                if (hl) begin
                    mState = 2; mValid = 1'b0; mHalted = 1'b1;
                end else if (st) begin
                end else if (jp) mPc = tgt;
                else if (rt && RAS_EN) begin
                    if (mStack.size() == 0) begin mPc = mPc + 8'd1; mErr = 1'b1; end
                    else mPc = mStack.pop_back();
                end else if (cl && RAS_EN) begin
                    if (mStack.size() == MODEL_DEPTH) begin mPc = mPc + 8'd1; mErr = 1'b1; end
                    else begin mStack.push_back(mPc + 8'd1); mPc = tgt; end
                end else if (br) mPc = mPc + {{3{off[4]}}, off};
                else mPc = mPc + 8'd1;
            end
            default: begin
                if (rs && !hl) begin mState = 1; mValid = 1'b1; mHalted = 1'b0; end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic st, br, input logic [4:0] off, input logic jp,
                                 input logic [7:0] tgt, input logic cl, rt, hl, rs);
        exp_t e;
        bus.stall = st; bus.branch_taken = br; bus.branch_offset = off;
        bus.jump = jp; bus.jump_target = tgt; bus.call = cl; bus.ret = rt;
        bus.halt = hl; bus.resume = rs;
        modelStep(st, br, off, jp, tgt, cl, rt, hl, rs);
        sbQueue.push_back('{pc: mPc, valid: mValid, halted: mHalted, err: mErr});
        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_underrun", 32'd1, 32'd0);
        end else begin
            e = sbQueue.pop_front();
            checkOutput("pc",       {24'd0, bus.PCinst}, {24'd0, e.pc});
            checkOutput("pc_valid", {31'd0, bus.pc_valid}, {31'd0, e.valid});
            checkOutput("halted",   {31'd0, bus.halted}, {31'd0, e.halted});
            checkOutput("ras_err",  {31'd0, bus.ras_err}, {31'd0, e.err});
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic jumpTo(input logic [7:0] t);
        applyStimulus(0, 0, 5'd0, 1, t, 0, 0, 0, 0);
    endtask

    task automatic clearInputs();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = 5'd0; bus.jump = 0;
        bus.jump_target = 8'h00; bus.call = 0; bus.ret = 0; bus.halt = 0; bus.resume = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"},     {24'd0, bus.PCinst}, 32'h00);
        checkOutput({tag, "_valid"},  {31'd0, bus.pc_valid}, 32'd0);
        checkOutput({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
        checkOutput({tag, "_err"},    {31'd0, bus.ras_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        modelReset();
        rst = 1'b1;
        #12;
        checkResetState("reset");
        @(negedge clk);
        rst = 1'b0;

        // boot cycle then sequential fetch
        idle();
        checkOutput("boot_pc0", {24'd0, bus.PCinst}, 32'h00);
        idle();
        idle();
        checkOutput("seq_pc2", {24'd0, bus.PCinst}, 32'h02);

        jumpTo(8'hFF);
        idle();
        checkOutput("wrap", {24'd0, bus.PCinst}, 32'h00);

        jumpTo(8'h10);
        applyStimulus(0, 1, 5'b11100, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("branch_neg", {24'd0, bus.PCinst}, 32'h0C);
        jumpTo(8'h10);
        applyStimulus(0, 1, 5'b01111, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("branch_pos", {24'd0, bus.PCinst}, 32'h1F);
        jumpTo(8'h02);
        applyStimulus(0, 1, 5'b11100, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("branch_wrap", {24'd0, bus.PCinst}, 32'hFE);

        jumpTo(8'h20);
        applyStimulus(0, 1, 5'd3, 1, 8'h80, 0, 0, 0, 0);
        checkOutput("jump_over_branch", {24'd0, bus.PCinst}, 32'h80);
        jumpTo(8'h20);
        applyStimulus(1, 1, 5'd3, 1, 8'h80, 0, 0, 0, 0);
        checkOutput("stall_wins", {24'd0, bus.PCinst}, 32'h20);

        jumpTo(8'h05);
        applyStimulus(0, 0, 5'd0, 1, 8'h99, 0, 0, 1, 0);
        checkOutput("halt_pc", {24'd0, bus.PCinst}, 32'h05);
        checkOutput("halt_flag", {31'd0, bus.halted}, 32'd1);
        applyStimulus(0, 1, 5'd4, 1, 8'h77, 0, 0, 0, 0);
        applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 0, 1, 1);
        checkOutput("halt_resume_both", {31'd0, bus.halted}, 32'd1);
        applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("resume_pc", {24'd0, bus.PCinst}, 32'h05);
        idle();
        checkOutput("after_resume", {24'd0, bus.PCinst}, 32'h06);

`ifdef PC_RETURN_STACK_EN
        jumpTo(8'h03);
        applyStimulus(0, 0, 5'd0, 0, 8'h40, 1, 0, 0, 0);
        checkOutput("call_pc", {24'd0, bus.PCinst}, 32'h40);
        applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 1, 0, 0);
        checkOutput("ret_pc", {24'd0, bus.PCinst}, 32'h04);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 5'd0, 0, 8'h50 + 8'(i * 16), 1, 0, 0, 0);
        checkOutput("overflow_err", {31'd0, bus.ras_err}, 32'd1);
        checkOutput("overflow_pc", {24'd0, bus.PCinst}, 32'h81);
        idle();
        checkOutput("err_clears", {31'd0, bus.ras_err}, 32'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 1, 0, 0);
        checkOutput("unwind_pc", {24'd0, bus.PCinst}, 32'h05);
        applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 1, 0, 0);
        checkOutput("underflow_err", {31'd0, bus.ras_err}, 32'd1);
        checkOutput("underflow_pc", {24'd0, bus.PCinst}, 32'h06);
`else
        jumpTo(8'h30);
        applyStimulus(0, 0, 5'd0, 0, 8'h40, 1, 0, 0, 0);
        checkOutput("call_ignored", {24'd0, bus.PCinst}, 32'h31);
        applyStimulus(0, 0, 5'd0, 0, 8'h00, 0, 1, 0, 0);
        checkOutput("ret_ignored", {24'd0, bus.PCinst}, 32'h32);
        checkOutput("err_tied", {31'd0, bus.ras_err}, 32'd0);
`endif

        // reset in the middle of operation takes effect without a clock edge
        jumpTo(8'hA7);
        rst = 1'b1;
        #1;
        checkResetState("midreset");
        clearInputs();
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();
        checkOutput("post_reset_pc", {24'd0, bus.PCinst}, 32'h01);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(7) == 0), ($urandom_range(3) == 0),
                          5'($urandom_range(31)), ($urandom_range(7) == 0),
                          8'($urandom_range(255)), ($urandom_range(4) == 0),
                          ($urandom_range(4) == 0), ($urandom_range(15) == 0),
                          ($urandom_range(3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
